// File: rtl/qbert_spi_pkg.sv
// Shared constants and types for the Q*bert SPI game-data receiver.
// Frame: header 0xA5, game_status, jump, acc, and (SPI_CHECKSUM_EN) an XOR checksum.
// Optional feature macro: SPI_CHECKSUM_EN adds the checksum byte and the CHECK state.
package qbert_spi_pkg;

  localparam int unsigned BYTE_W     = 8;
  localparam int unsigned BIT_CNT_W  = 3;
  localparam int unsigned BYTE_IDX_W = 3;

  localparam logic [BYTE_W-1:0] SPI_HEADER = 8'hA5;

  // Position of each byte within a frame
  localparam logic [BYTE_IDX_W-1:0] BYTE_HEADER = 3'd0;
  localparam logic [BYTE_IDX_W-1:0] BYTE_STATUS = 3'd1;
  localparam logic [BYTE_IDX_W-1:0] BYTE_JUMP   = 3'd2;
  localparam logic [BYTE_IDX_W-1:0] BYTE_ACC    = 3'd3;
  localparam logic [BYTE_IDX_W-1:0] BYTE_CSUM   = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_HEADER  = 3'd1,
    ST_PAYLOAD = 3'd2,
    ST_COMMIT  = 3'd3,
    ST_DISCARD = 3'd4
`ifdef SPI_CHECKSUM_EN
    ,
    ST_CHECK   = 3'd5
`endif
  } spi_state_t;

  typedef struct packed {
    logic [BYTE_W-1:0] status;
    logic [BYTE_W-1:0] jump;
    logic [BYTE_W-1:0] acc;
  } spi_payload_t;

  function automatic logic [BYTE_W-1:0] payload_csum(input spi_payload_t p);
    return p.status ^ p.jump ^ p.acc;
  endfunction

endpackage

// File: rtl/spi_sync.sv
// Two-flop synchronizer plus a history flop for edge detection.
// Ports: Avalon_CLK_50/iRST_n clock and async active-low reset; din async input;
//        dout synchronized level; rise_c/fall_c single-cycle edge strobes (combinational).
// IDLE_LVL is the level the flops reset to, so no false edge appears at reset.
module spi_sync #(
  parameter logic IDLE_LVL = 1'b0
) (
  input  logic Avalon_CLK_50,
  input  logic iRST_n,
  input  logic din,
  output logic dout,
  output logic rise_c,
  output logic fall_c
);

  logic meta;
  logic sync;
  logic prev;

  always_ff @(posedge Avalon_CLK_50 or negedge iRST_n) begin
    if (!iRST_n) begin
      meta <= IDLE_LVL;
      sync <= IDLE_LVL;
      prev <= IDLE_LVL;
    end else begin
      meta <= din;
      sync <= meta;
      prev <= sync;
    end
  end

  assign dout   = sync;
  assign rise_c = sync & ~prev;
  assign fall_c = ~sync & prev;

endmodule

// File: rtl/spi_game_receiver.sv
// SPI mode-0 slave that receives game-data frames from the PIC32 and presents the
// last good payload to the MTL display controller.
// Ports: Avalon_CLK_50 clock, iRST_n async active-low reset;
//        iSPI_SCLK/iSPI_CS_n/iSPI_MOSI SPI pins (MSB first);
//        oSPI_game_status/oSPI_jump/oSPI_acc committed payload;
//        oFrame_valid / oFrame_err one-cycle pulses; oErr_count saturating reject count.
// Optional feature macro: SPI_CHECKSUM_EN (5-byte frames with XOR checksum).
module spi_game_receiver
  import qbert_spi_pkg::*;
(
  input  logic       Avalon_CLK_50,
  input  logic       iRST_n,
  input  logic       iSPI_SCLK,
  input  logic       iSPI_CS_n,
  input  logic       iSPI_MOSI,
  output logic [7:0] oSPI_game_status,
  output logic [7:0] oSPI_jump,
  output logic [7:0] oSPI_acc,
  output logic       oFrame_valid,
  output logic       oFrame_err,
  output logic [7:0] oErr_count
);

  logic sclk_lvl_unused, sclk_rise_c, sclk_fall_unused;
  logic cs_sync, cs_rise_c, cs_fall_c;
  logic mosi_sync, mosi_rise_unused, mosi_fall_unused;

  spi_sync #(.IDLE_LVL(1'b0)) u_sync_sclk (
    .Avalon_CLK_50(Avalon_CLK_50), .iRST_n(iRST_n), .din(iSPI_SCLK),
    .dout(sclk_lvl_unused), .rise_c(sclk_rise_c), .fall_c(sclk_fall_unused)
  );

  spi_sync #(.IDLE_LVL(1'b1)) u_sync_cs (
    .Avalon_CLK_50(Avalon_CLK_50), .iRST_n(iRST_n), .din(iSPI_CS_n),
    .dout(cs_sync), .rise_c(cs_rise_c), .fall_c(cs_fall_c)
  );

  spi_sync #(.IDLE_LVL(1'b0)) u_sync_mosi (
    .Avalon_CLK_50(Avalon_CLK_50), .iRST_n(iRST_n), .din(iSPI_MOSI),
    .dout(mosi_sync), .rise_c(mosi_rise_unused), .fall_c(mosi_fall_unused)
  );

  spi_state_t               state_q, state_d;
  logic [BYTE_W-2:0]        shift_q;     // seven older bits; the live MOSI sample is the eighth
  logic [BIT_CNT_W-1:0]     bit_cnt_q;
  logic [BYTE_IDX_W-1:0]    byte_idx_q;
  spi_payload_t             shadow_q;
  logic [1:0]               settle_q;
  logic                     armed_q;

  logic                     rx_state_c;
  logic                     sample_c;
  logic                     byte_done_c;
  logic [BYTE_W-1:0]        byte_c;
  logic                     err_c;

  // Receiving states; DISCARD and IDLE ignore SCLK entirely
  always_comb begin
    rx_state_c = (state_q == ST_HEADER) || (state_q == ST_PAYLOAD)
`ifdef SPI_CHECKSUM_EN
                 || (state_q == ST_CHECK)
`endif
                 ;
  end

  // A CS rise coincident with an SCLK rise still takes that final bit
  assign sample_c    = rx_state_c & sclk_rise_c & (~cs_sync | cs_rise_c);
  assign byte_done_c = sample_c & (bit_cnt_q == 3'd7);
  assign byte_c      = {shift_q, mosi_sync};

  // FSM state register
  always_ff @(posedge Avalon_CLK_50 or negedge iRST_n) begin
    if (!iRST_n) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  // FSM next state and error strobe; a completed byte wins over a coincident CS rise
  always_comb begin
    state_d = state_q;
    err_c   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (cs_fall_c && armed_q) state_d = ST_HEADER;
      end
      ST_HEADER: begin
        if (byte_done_c && (byte_c == SPI_HEADER) && !cs_rise_c) begin
          state_d = ST_PAYLOAD;
        end else if (byte_done_c || cs_rise_c) begin
          err_c   = 1'b1;
          state_d = cs_rise_c ? ST_IDLE : ST_DISCARD;
        end
      end
      ST_PAYLOAD: begin
        if (byte_done_c && (byte_idx_q == BYTE_ACC)) begin
`ifdef SPI_CHECKSUM_EN
          if (cs_rise_c) begin
            err_c   = 1'b1;
            state_d = ST_IDLE;
          end else begin
            state_d = ST_CHECK;
          end
`else
          state_d = ST_COMMIT;
`endif
        end else if (cs_rise_c) begin
          err_c   = 1'b1;
          state_d = ST_IDLE;
        end
      end
`ifdef SPI_CHECKSUM_EN
      ST_CHECK: begin
        if (byte_done_c) begin
          if (byte_c == payload_csum(shadow_q)) begin
            state_d = ST_COMMIT;
          end else begin
            err_c   = 1'b1;
            state_d = cs_rise_c ? ST_IDLE : ST_DISCARD;
          end
        end else if (cs_rise_c) begin
          err_c   = 1'b1;
          state_d = ST_IDLE;
        end
      end
`endif
      // CS may already be high if it rose with the last bit; skip DISCARD then
      ST_COMMIT: begin
        state_d = cs_sync ? ST_IDLE : ST_DISCARD;
      end
      ST_DISCARD: begin
        if (cs_rise_c) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath: shifter, counters, shadow payload and registered outputs
  always_ff @(posedge Avalon_CLK_50 or negedge iRST_n) begin
    if (!iRST_n) begin
      shift_q          <= '0;
      bit_cnt_q        <= '0;
      byte_idx_q       <= BYTE_HEADER;
      shadow_q         <= '0;
      settle_q         <= '0;
      armed_q          <= 1'b0;
      oSPI_game_status <= '0;
      oSPI_jump        <= '0;
      oSPI_acc         <= '0;
      oFrame_valid     <= 1'b0;
      oFrame_err       <= 1'b0;
      oErr_count       <= '0;
    end else begin
      // After reset, only arm once the synchronizers hold real pin values and CS is high,
      // so a frame cut by reset is never picked up halfway
      if (settle_q != 2'd3) settle_q <= settle_q + 2'd1;
      else if (cs_sync)     armed_q  <= 1'b1;

      if (state_q == ST_IDLE) begin
        shift_q    <= '0;
        bit_cnt_q  <= '0;
        byte_idx_q <= BYTE_HEADER;
      end else if (sample_c) begin
        shift_q   <= byte_c[BYTE_W-2:0];
        bit_cnt_q <= bit_cnt_q + 3'd1;
        if (bit_cnt_q == 3'd7) byte_idx_q <= byte_idx_q + 3'd1;
      end

      if (byte_done_c && (state_q == ST_PAYLOAD)) begin
        case (byte_idx_q)
          BYTE_STATUS: shadow_q.status <= byte_c;
          BYTE_JUMP:   shadow_q.jump   <= byte_c;
          BYTE_ACC:    shadow_q.acc    <= byte_c;
          default:     ;
        endcase
      end

      oFrame_valid <= (state_q == ST_COMMIT);
      oFrame_err   <= err_c;
      if (state_q == ST_COMMIT) begin
        oSPI_game_status <= shadow_q.status;
        oSPI_jump        <= shadow_q.jump;
        oSPI_acc         <= shadow_q.acc;
      end
      if (err_c && (oErr_count != 8'hFF)) oErr_count <= oErr_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_spi_game_receiver.sv
`timescale 1ns/1ps
module tb_spi_game_receiver;

`ifdef SPI_CHECKSUM_EN
  localparam int FRAME_BITS = 40;
`else
  localparam int FRAME_BITS = 32;
`endif
  localparam int HALF = 4;  // SCLK half period in system clocks (SCLK = clk/8)
  localparam int NVEC = 6;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sclk = 1'b0;
  logic       cs_n = 1'b1;
  logic       mosi = 1'b0;
  logic [7:0] st, jp, acc, ecnt;
  logic       fv, fe;

  spi_game_receiver dut (
    .Avalon_CLK_50(clk), .iRST_n(rst_n),
    .iSPI_SCLK(sclk), .iSPI_CS_n(cs_n), .iSPI_MOSI(mosi),
    .oSPI_game_status(st), .oSPI_jump(jp), .oSPI_acc(acc),
    .oFrame_valid(fv), .oFrame_err(fe), .oErr_count(ecnt)
  );

  always #10 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Pulse monitor, sampled on the falling edge
  int valid_pulses = 0;
  int err_pulses   = 0;
  int valid_cyc    = 0;
  int both_seen    = 0;
  always @(negedge clk) begin
    if (rst_n) begin
      if (fv) begin
        valid_pulses = valid_pulses + 1;
        valid_cyc    = cyc;
      end
      if (fe) err_pulses = err_pulses + 1;
      if (fv && fe) both_seen = both_seen + 1;
    end
  end

  int checks = 0;
  int errors = 0;
  int frame_rise = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic shift_bits(input logic [39:0] data, input int nbits, input bit cs_with_last);
    for (int i = 0; i < nbits; i++) begin
      mosi = data[39-i];
      tick(HALF);
      sclk = 1'b1;
      if (i == FRAME_BITS - 1) frame_rise = cyc;
      if (cs_with_last && (i == nbits - 1)) cs_n = 1'b1;
      tick(HALF);
      sclk = 1'b0;
    end
  endtask

  task automatic send_frame(input logic [39:0] data, input int nbits, input bit cs_with_last);
    cs_n = 1'b0;
    tick(HALF);
    shift_bits(data, nbits, cs_with_last);
    tick(HALF);
    cs_n = 1'b1;
    tick(12);
  endtask

  typedef struct {
    logic [39:0] data;
    int          nbits;
    int          exp_valid;
    int          exp_err;
    logic [7:0]  exp_st;
    logic [7:0]  exp_jp;
    logic [7:0]  exp_acc;
    logic [7:0]  exp_ecnt;
  } vec_t;

  vec_t vecs [NVEC];

  initial begin
    int v0, e0;
`ifdef SPI_CHECKSUM_EN
    vecs[0] = '{40'hA503027F7E, 40, 1, 0, 8'h03, 8'h02, 8'h7F, 8'd0};
    vecs[1] = '{40'h5A11223300, 40, 0, 1, 8'h03, 8'h02, 8'h7F, 8'd1};
    vecs[2] = '{40'hA510203000, 20, 0, 1, 8'h03, 8'h02, 8'h7F, 8'd2};
    vecs[3] = '{40'hA5010203FF, 40, 0, 1, 8'h03, 8'h02, 8'h7F, 8'd3};
    vecs[4] = '{40'hA501020300, 40, 1, 0, 8'h01, 8'h02, 8'h03, 8'd3};
    vecs[5] = '{40'hA5AA55FF00, 32, 0, 1, 8'h01, 8'h02, 8'h03, 8'd4};
`else
    vecs[0] = '{40'hA503027F00, 32, 1, 0, 8'h03, 8'h02, 8'h7F, 8'd0};
    vecs[1] = '{40'h5A11223300, 32, 0, 1, 8'h03, 8'h02, 8'h7F, 8'd1};
    vecs[2] = '{40'hA510203000, 20, 0, 1, 8'h03, 8'h02, 8'h7F, 8'd2};
    vecs[3] = '{40'hA510203000, 32, 1, 0, 8'h10, 8'h20, 8'h30, 8'd2};
    vecs[4] = '{40'hA5AA55FF00, 40, 1, 0, 8'hAA, 8'h55, 8'hFF, 8'd2};
    vecs[5] = '{40'hA5C3000100, 24, 0, 1, 8'hAA, 8'h55, 8'hFF, 8'd3};
`endif

    // Reset state
    tick(3);
    chk("reset status", 32'(st), 32'h0);
    chk("reset jump",   32'(jp), 32'h0);
    chk("reset acc",    32'(acc), 32'h0);
    chk("reset valid",  32'(fv), 32'h0);
    chk("reset err",    32'(fe), 32'h0);
    chk("reset errcnt", 32'(ecnt), 32'h0);
    rst_n = 1'b1;
    tick(8);

    // Table-driven frames
    for (int i = 0; i < NVEC; i++) begin
      v0 = valid_pulses;
      e0 = err_pulses;
      send_frame(vecs[i].data, vecs[i].nbits, 1'b0);
      chk($sformatf("vec%0d valid pulses", i), 32'(valid_pulses - v0), 32'(vecs[i].exp_valid));
      chk($sformatf("vec%0d err pulses", i), 32'(err_pulses - e0), 32'(vecs[i].exp_err));
      chk($sformatf("vec%0d status", i), 32'(st), 32'(vecs[i].exp_st));
      chk($sformatf("vec%0d jump", i), 32'(jp), 32'(vecs[i].exp_jp));
      chk($sformatf("vec%0d acc", i), 32'(acc), 32'(vecs[i].exp_acc));
      chk($sformatf("vec%0d errcnt", i), 32'(ecnt), 32'(vecs[i].exp_ecnt));
      if (vecs[i].exp_valid == 1 && vecs[i].nbits >= FRAME_BITS)
        chk($sformatf("vec%0d latency", i), 32'(valid_cyc - frame_rise), 32'd4);
    end

    // CS rises together with the final SCLK edge: frame still commits, then next frame works
    v0 = valid_pulses;
    e0 = err_pulses;
    send_frame(40'hA55A3C6600, FRAME_BITS, 1'b1);
    chk("coincident valid", 32'(valid_pulses - v0), 32'd1);
    chk("coincident err",   32'(err_pulses - e0), 32'd0);
    chk("coincident status", 32'(st), 32'h5A);
    chk("coincident acc",    32'(acc), 32'h66);
    chk("coincident latency", 32'(valid_cyc - frame_rise), 32'd4);
    v0 = valid_pulses;
    send_frame(40'hA501020407, FRAME_BITS, 1'b0);
    chk("after coincident valid", 32'(valid_pulses - v0), 32'd1);
    chk("after coincident acc",   32'(acc), 32'h04);

    // Error counter saturation
    e0 = err_pulses;
    for (int k = 0; k < 300; k++) send_frame(40'h5A00000000, 8, 1'b0);
    chk("sat err pulses", 32'(err_pulses - e0), 32'd300);
    chk("sat errcnt",     32'(ecnt), 32'd255);
    send_frame(40'h5A00000000, 8, 1'b0);
    chk("sat errcnt hold", 32'(ecnt), 32'd255);
    chk("sat outputs hold", 32'(acc), 32'h04);

    // Reset in the middle of a frame
    v0 = valid_pulses;
    e0 = err_pulses;
    cs_n = 1'b0;
    tick(HALF);
    shift_bits(40'hA577665544, 12, 1'b0);
    rst_n = 1'b0;
    tick(2);
    chk("midrst status", 32'(st), 32'h0);
    chk("midrst jump",   32'(jp), 32'h0);
    chk("midrst acc",    32'(acc), 32'h0);
    chk("midrst errcnt", 32'(ecnt), 32'h0);
    rst_n = 1'b1;
    shift_bits(40'h7766554433, 20, 1'b0);
    tick(HALF);
    cs_n = 1'b1;
    tick(12);
    chk("midrst no valid", 32'(valid_pulses - v0), 32'd0);
    chk("midrst no err",   32'(err_pulses - e0), 32'd0);
    chk("midrst acc still 0", 32'(acc), 32'h0);
    send_frame(40'hA511223300, FRAME_BITS, 1'b0);
    chk("post-reset valid",  32'(valid_pulses - v0), 32'd1);
    chk("post-reset status", 32'(st), 32'h11);
    chk("post-reset jump",   32'(jp), 32'h22);
    chk("post-reset acc",    32'(acc), 32'h33);

    chk("valid/err overlap", 32'(both_seen), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #10ms;
    $display("FAIL watchdog: simulation did not complete, time %0t", $time);
    $fatal(1);
  end

endmodule
